// File: rtl/forwarding_scoreboard.sv
// Operand forwarding and load-use hazard unit: a DEPTH-entry shift scoreboard of
// in-flight register writes, searched youngest-first for each decode source.

module forwarding_scoreboard_lane #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 3,
  parameter int SELW   = $clog2(DEPTH+2)
) (
  input  logic [AWIDTH-1:0]             rs,
  input  logic [DWIDTH-1:0]             reg_data,
  input  logic [DEPTH:0]                slot_wr,
  input  logic [DEPTH:0][AWIDTH-1:0]    slot_rd,
  input  logic [DEPTH:0][DWIDTH-1:0]    slot_data,
  input  logic [DEPTH:0]                slot_pend,
  output logic [DWIDTH-1:0]             data,
  output logic [SELW-1:0]               sel,
  output logic                          stall
);
  logic found;

  // Slot 0 is the live ALU stage, slot k is E[k]; lowest index wins.
  always_comb begin
    data  = reg_data;
    sel   = '0;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (!found && slot_wr[i] && (slot_rd[i] == rs) && (rs != '0)) begin
        found = 1'b1;
        data  = slot_data[i];
        sel   = SELW'(i + 1);
        stall = slot_pend[i];
      end
    end
  end
endmodule

module forwarding_scoreboard #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int DEPTH     = 3,
  parameter int MAX_STALL = 15,
  parameter int SELW      = $clog2(DEPTH+2)
) (
  input  logic                              h_clk,
  input  logic                              h_rst,
  input  logic                              h_i_adv,
  input  logic                              h_i_flush,
  input  logic                              h_i_valid_alu,
  input  logic                              h_i_we_reg_alu,
  input  logic                              h_i_is_load,
  input  logic [AWIDTH-1:0]                 h_i_alu_addr_rd,
  input  logic [DWIDTH-1:0]                 h_i_alu_data_rd,
  input  logic                              h_i_load_valid,
  input  logic [DWIDTH-1:0]                 h_i_load_data,
  input  logic [AWIDTH-1:0]                 h_decoder_addr_rs1,
  input  logic [AWIDTH-1:0]                 h_decoder_addr_rs2,
  input  logic [DWIDTH-1:0]                 h_data_reg_rs1,
  input  logic [DWIDTH-1:0]                 h_data_reg_rs2,
  output logic [DWIDTH-1:0]                 h_data_out_rs1,
  output logic [DWIDTH-1:0]                 h_data_out_rs2,
  output logic [SELW-1:0]                   h_o_fwd_sel_rs1,
  output logic [SELW-1:0]                   h_o_fwd_sel_rs2,
  output logic                              h_alu_force_stall_out,
  output logic [$clog2(MAX_STALL+1)-1:0]    h_o_stall_cnt,
  output logic                              h_o_stall_timeout
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(MAX_STALL+1);

  logic [DEPTH:1]              ent_vld, ent_we, ent_pend;
  logic [DEPTH:1][AWIDTH-1:0]  ent_rd;
  logic [DEPTH:1][DWIDTH-1:0]  ent_data;

  logic [DEPTH:1]              nxt_vld, nxt_we, nxt_pend;
  logic [DEPTH:1][AWIDTH-1:0]  nxt_rd;
  logic [DEPTH:1][DWIDTH-1:0]  nxt_data;
  logic                        ld_done;

  logic [DEPTH:0]              slot_wr, slot_pend;
  logic [DEPTH:0][AWIDTH-1:0]  slot_rd;
  logic [DEPTH:0][DWIDTH-1:0]  slot_data;

  logic [NUM_LANES-1:0][AWIDTH-1:0] lane_rs;
  logic [NUM_LANES-1:0][DWIDTH-1:0] lane_reg, lane_data;
  logic [NUM_LANES-1:0][SELW-1:0]   lane_sel;
  logic [NUM_LANES-1:0]             lane_stall;

  logic [CW-1:0] stall_cnt;
  logic          timeout;

  assign slot_wr   = {ent_vld & ent_we, h_i_valid_alu & h_i_we_reg_alu};
  assign slot_rd   = {ent_rd,   h_i_alu_addr_rd};
  assign slot_data = {ent_data, h_i_alu_data_rd};
  assign slot_pend = {ent_pend, h_i_is_load};

  assign lane_rs  = {h_decoder_addr_rs2, h_decoder_addr_rs1};
  assign lane_reg = {h_data_reg_rs2, h_data_reg_rs1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    forwarding_scoreboard_lane #(
      .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .SELW(SELW)
    ) u_lane (
      .rs        (lane_rs[g]),
      .reg_data  (lane_reg[g]),
      .slot_wr   (slot_wr),
      .slot_rd   (slot_rd),
      .slot_data (slot_data),
      .slot_pend (slot_pend),
      .data      (lane_data[g]),
      .sel       (lane_sel[g]),
      .stall     (lane_stall[g])
    );
  end

  assign h_data_out_rs1        = lane_data[0];
  assign h_data_out_rs2        = lane_data[1];
  assign h_o_fwd_sel_rs1       = lane_sel[0];
  assign h_o_fwd_sel_rs2       = lane_sel[1];
  assign h_alu_force_stall_out = |lane_stall;
  assign h_o_stall_cnt         = stall_cnt;
  assign h_o_stall_timeout     = timeout;

  // Load return lands in the oldest pending entry first, then the shift moves it.
  always_comb begin
    nxt_vld  = ent_vld;
    nxt_we   = ent_we;
    nxt_rd   = ent_rd;
    nxt_data = ent_data;
    nxt_pend = ent_pend;
    ld_done  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (h_i_load_valid && !ld_done && ent_vld[k] && ent_pend[k]) begin
        ld_done     = 1'b1;
        nxt_pend[k] = 1'b0;
        nxt_data[k] = h_i_load_data;
      end
    end
    if (h_i_adv) begin
      for (int k = DEPTH; k >= 2; k--) begin
        nxt_vld[k]  = nxt_vld[k-1];
        nxt_we[k]   = nxt_we[k-1];
        nxt_rd[k]   = nxt_rd[k-1];
        nxt_data[k] = nxt_data[k-1];
        nxt_pend[k] = nxt_pend[k-1];
      end
      nxt_vld[1]  = h_i_valid_alu;
      nxt_we[1]   = h_i_we_reg_alu;
      nxt_rd[1]   = h_i_alu_addr_rd;
      nxt_data[1] = h_i_alu_data_rd;
      nxt_pend[1] = h_i_is_load;
    end
  end

  always_ff @(posedge h_clk or negedge h_rst) begin
    if (!h_rst) begin
      ent_vld   <= '0;
      ent_we    <= '0;
      ent_rd    <= '0;
      ent_data  <= '0;
      ent_pend  <= '0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else if (h_i_flush) begin
      ent_vld   <= '0;
      ent_pend  <= '0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      ent_vld  <= nxt_vld;
      ent_we   <= nxt_we;
      ent_rd   <= nxt_rd;
      ent_data <= nxt_data;
      ent_pend <= nxt_pend;
      if (h_alu_force_stall_out) begin
        if (stall_cnt != CW'(MAX_STALL)) stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt == CW'(MAX_STALL - 1)) timeout <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: forwarding priority, load-use stall,
// stall counter saturation/timeout, flush and asynchronous reset.

module tb_forwarding_scoreboard;
  localparam int DWIDTH = 32, AWIDTH = 5, DEPTH = 3, MAX_STALL = 15;
  localparam int SELW = $clog2(DEPTH+2);
  localparam int CW   = $clog2(MAX_STALL+1);

  logic h_clk = 1'b0, h_rst = 1'b0;
  logic h_i_adv = 0, h_i_flush = 0, h_i_valid_alu = 0, h_i_we_reg_alu = 0, h_i_is_load = 0;
  logic [AWIDTH-1:0] h_i_alu_addr_rd = '0, h_decoder_addr_rs1 = '0, h_decoder_addr_rs2 = '0;
  logic [DWIDTH-1:0] h_i_alu_data_rd = '0, h_i_load_data = '0, h_data_reg_rs1 = '0, h_data_reg_rs2 = '0;
  logic h_i_load_valid = 0;
  logic [DWIDTH-1:0] h_data_out_rs1, h_data_out_rs2;
  logic [SELW-1:0]   h_o_fwd_sel_rs1, h_o_fwd_sel_rs2;
  logic              h_alu_force_stall_out, h_o_stall_timeout;
  logic [CW-1:0]     h_o_stall_cnt;

  int n_cmp = 0, n_bad = 0;

  always #5 h_clk = ~h_clk;

  forwarding_scoreboard #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .MAX_STALL(MAX_STALL)
  ) dut (
    .h_clk(h_clk), .h_rst(h_rst), .h_i_adv(h_i_adv), .h_i_flush(h_i_flush),
    .h_i_valid_alu(h_i_valid_alu), .h_i_we_reg_alu(h_i_we_reg_alu), .h_i_is_load(h_i_is_load),
    .h_i_alu_addr_rd(h_i_alu_addr_rd), .h_i_alu_data_rd(h_i_alu_data_rd),
    .h_i_load_valid(h_i_load_valid), .h_i_load_data(h_i_load_data),
    .h_decoder_addr_rs1(h_decoder_addr_rs1), .h_decoder_addr_rs2(h_decoder_addr_rs2),
    .h_data_reg_rs1(h_data_reg_rs1), .h_data_reg_rs2(h_data_reg_rs2),
    .h_data_out_rs1(h_data_out_rs1), .h_data_out_rs2(h_data_out_rs2),
    .h_o_fwd_sel_rs1(h_o_fwd_sel_rs1), .h_o_fwd_sel_rs2(h_o_fwd_sel_rs2),
    .h_alu_force_stall_out(h_alu_force_stall_out),
    .h_o_stall_cnt(h_o_stall_cnt), .h_o_stall_timeout(h_o_stall_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic set_live(input logic v, input logic ld, input logic [AWIDTH-1:0] rd,
                          input logic [DWIDTH-1:0] d);
    h_i_valid_alu   = v;
    h_i_we_reg_alu  = 1'b1;
    h_i_is_load     = ld;
    h_i_alu_addr_rd = rd;
    h_i_alu_data_rd = d;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_stall", 32'(h_alu_force_stall_out), 0);
    chk("rst_cnt",   32'(h_o_stall_cnt), 0);
    chk("rst_tmo",   32'(h_o_stall_timeout), 0);
    h_rst = 1'b1;
    tick();

    // rs=0 never forwards
    h_data_reg_rs1 = 32'h77;
    set_live(1, 0, 5'd0, 32'd109);
    h_decoder_addr_rs1 = 5'd0;
    #1;
    chk("x0_out",   h_data_out_rs1, 32'h77);
    chk("x0_sel",   32'(h_o_fwd_sel_rs1), 0);
    chk("x0_stall", 32'(h_alu_force_stall_out), 0);

    // live slot forwarding gated by valid
    h_decoder_addr_rs1 = 5'd10;
    h_data_reg_rs1     = 32'd100;
    set_live(0, 0, 5'd10, 32'd109);
    #1;
    chk("l_inv_out", h_data_out_rs1, 32'd100);
    chk("l_inv_sel", 32'(h_o_fwd_sel_rs1), 0);
    h_i_valid_alu = 1'b1;
    #1;
    chk("l_v_out", h_data_out_rs1, 32'd109);
    chk("l_v_sel", 32'(h_o_fwd_sel_rs1), 1);

    // youngest wins, then the entry ages out through DEPTH stages
    h_decoder_addr_rs2 = 5'd12;
    h_data_reg_rs2     = 32'd50;
    set_live(1, 0, 5'd12, 32'd111);
    h_i_adv = 1'b1;
    tick();
    set_live(1, 0, 5'd12, 32'd222);
    #1;
    chk("yng_out", h_data_out_rs2, 32'd222);
    chk("yng_sel", 32'(h_o_fwd_sel_rs2), 1);
    h_i_valid_alu = 1'b0;
    #1;
    chk("e1_out", h_data_out_rs2, 32'd111);
    chk("e1_sel", 32'(h_o_fwd_sel_rs2), 2);
    tick();
    chk("e2_sel", 32'(h_o_fwd_sel_rs2), 3);
    tick();
    chk("e3_out", h_data_out_rs2, 32'd111);
    chk("e3_sel", 32'(h_o_fwd_sel_rs2), 4);
    tick();
    chk("aged_out", h_data_out_rs2, 32'd50);
    chk("aged_sel", 32'(h_o_fwd_sel_rs2), 0);

    // load-use stall and completion
    set_live(1, 1, 5'd5, 32'h1234);
    tick();
    h_i_adv = 1'b0;
    h_i_valid_alu = 1'b0;
    h_decoder_addr_rs1 = 5'd5;
    h_data_reg_rs1     = 32'h55;
    #1;
    chk("lu_stall", 32'(h_alu_force_stall_out), 1);
    chk("lu_sel",   32'(h_o_fwd_sel_rs1), 2);
    chk("lu_out",   h_data_out_rs1, 32'h1234);
    tick(); tick(); tick();
    chk("lu_cnt3", 32'(h_o_stall_cnt), 3);
    h_i_load_valid = 1'b1;
    h_i_load_data  = 32'hDEAD;
    tick();
    h_i_load_valid = 1'b0;
    chk("ld_out",   h_data_out_rs1, 32'hDEAD);
    chk("ld_stall", 32'(h_alu_force_stall_out), 0);
    tick();
    chk("ld_cnt0",  32'(h_o_stall_cnt), 0);
    chk("ld_keep",  h_data_out_rs1, 32'hDEAD);

    // counter saturation, sticky timeout, flush
    set_live(1, 1, 5'd7, 32'h0);
    h_i_adv = 1'b1;
    tick();
    h_i_adv = 1'b0;
    h_i_valid_alu = 1'b0;
    h_decoder_addr_rs1 = 5'd7;
    h_data_reg_rs1     = 32'h70;
    for (int i = 0; i < MAX_STALL - 1; i++) tick();
    chk("cnt14", 32'(h_o_stall_cnt), MAX_STALL - 1);
    chk("tmo0",  32'(h_o_stall_timeout), 0);
    tick();
    chk("cnt15", 32'(h_o_stall_cnt), MAX_STALL);
    chk("tmo1",  32'(h_o_stall_timeout), 1);
    tick(); tick();
    chk("cnt_sat",  32'(h_o_stall_cnt), MAX_STALL);
    chk("tmo_hold", 32'(h_o_stall_timeout), 1);
    h_i_flush = 1'b1;
    tick();
    h_i_flush = 1'b0;
    chk("fl_tmo",   32'(h_o_stall_timeout), 0);
    chk("fl_cnt",   32'(h_o_stall_cnt), 0);
    chk("fl_stall", 32'(h_alu_force_stall_out), 0);
    chk("fl_out",   h_data_out_rs1, 32'h70);
    chk("fl_sel",   32'(h_o_fwd_sel_rs1), 0);

    // asynchronous reset in the middle of a stall
    set_live(1, 0, 5'd8, 32'h88);
    h_i_adv = 1'b1;
    tick();
    set_live(1, 1, 5'd9, 32'h0);
    tick();
    h_i_adv = 1'b0;
    h_i_valid_alu = 1'b0;
    h_decoder_addr_rs1 = 5'd9;
    h_decoder_addr_rs2 = 5'd8;
    h_data_reg_rs1 = 32'h90;
    h_data_reg_rs2 = 32'h80;
    #1;
    chk("pr_stall", 32'(h_alu_force_stall_out), 1);
    chk("pr_out2",  h_data_out_rs2, 32'h88);
    chk("pr_sel2",  32'(h_o_fwd_sel_rs2), 3);
    tick();
    chk("pr_cnt1",  32'(h_o_stall_cnt), 1);
    #2;
    h_rst = 1'b0;
    #1;
    chk("ar_stall", 32'(h_alu_force_stall_out), 0);
    chk("ar_sel1",  32'(h_o_fwd_sel_rs1), 0);
    chk("ar_sel2",  32'(h_o_fwd_sel_rs2), 0);
    chk("ar_cnt",   32'(h_o_stall_cnt), 0);
    chk("ar_out1",  h_data_out_rs1, 32'h90);
    #2;
    h_rst = 1'b1;
    tick();
    set_live(1, 0, 5'd8, 32'h99);
    h_i_adv = 1'b1;
    tick();
    h_i_adv = 1'b0;
    h_i_valid_alu = 1'b0;
    #1;
    chk("po_out2", h_data_out_rs2, 32'h99);
    chk("po_sel2", 32'(h_o_fwd_sel_rs2), 2);
    chk("po_sel1", 32'(h_o_fwd_sel_rs1), 0);
    chk("po_out1", h_data_out_rs1, 32'h90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
